// File: rtl/mlp_mac_feeder_pkg.sv
// Shared definitions for the MLP layer operand sequencer.
// FSM encodings, default widths and the clog2-with-floor-1 helper.
package mlp_mac_feeder_pkg;

  localparam int A_W_DEF   = 8;
  localparam int B_W_DEF   = 8;
  localparam int ACC_W_DEF = 32;
  localparam int N_IN_DEF  = 4;
  localparam int N_OUT_DEF = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_STREAM,
    S_DRAIN,
    S_EMIT,
    S_FINISH
  } state_t;

  function automatic int clog2m1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mlp_mac_feeder_if.sv
// Result port of the MLP operand sequencer.
// Carries one accumulated neuron sum with its index under valid/ready.
interface mlp_mac_feeder_if
  import mlp_mac_feeder_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_W_DEF,
  parameter int YI_W      = clog2m1(N_OUT_DEF)
);

  logic                        y_valid;
  logic                        y_ready;
  logic signed [ACC_WIDTH-1:0] y_data;
  logic        [YI_W-1:0]      y_idx;

  modport master (
    output y_valid,
    output y_data,
    output y_idx,
    input  y_ready
  );

  modport slave (
    input  y_valid,
    input  y_data,
    input  y_idx,
    output y_ready
  );

endinterface

// File: rtl/mlp_mac_feeder.sv
// Operand sequencer feeding x[i] and w[j][i] into the layer MAC.
// Captures each neuron sum and hands it out on a valid/ready port.
module mlp_mac_feeder
  import mlp_mac_feeder_pkg::*;
#(
  parameter int A_WIDTH   = A_W_DEF,
  parameter int B_WIDTH   = B_W_DEF,
  parameter int ACC_WIDTH = ACC_W_DEF,
  parameter int N_IN      = N_IN_DEF,
  parameter int N_OUT     = N_OUT_DEF,
  parameter int XA_W      = clog2m1(N_IN),
  parameter int WA_W      = clog2m1(N_IN * N_OUT),
  parameter int YI_W      = clog2m1(N_OUT)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_start,
  output logic                        busy,
  output logic                        done,
  output logic        [XA_W-1:0]      x_addr,
  input  logic signed [A_WIDTH-1:0]   x_rdata,
  output logic        [WA_W-1:0]      w_addr,
  input  logic signed [B_WIDTH-1:0]   w_rdata,
  output logic                        mac_start,
  output logic                        mac_valid,
  output logic signed [A_WIDTH-1:0]   mac_a,
  output logic signed [B_WIDTH-1:0]   mac_b,
  input  logic signed [ACC_WIDTH-1:0] mac_result,
  mlp_mac_feeder_if.master            y
);

  localparam logic [XA_W-1:0] I_LAST = XA_W'(N_IN - 1);
  localparam logic [YI_W-1:0] J_LAST = YI_W'(N_OUT - 1);

  state_t state, state_nxt;

  logic [XA_W-1:0] i;
  logic [YI_W-1:0] j;
  logic            last_i;
  logic            last_j;
  logic            hs;
  logic            more_addr;

  assign last_i    = (i == I_LAST);
  assign last_j    = (j == J_LAST);
  assign hs        = y.y_valid & y.y_ready;
  assign more_addr = (int'(i) + 2) < N_IN;

  assign mac_a = x_rdata;
  assign mac_b = w_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (cmd_start) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_STREAM;
      S_STREAM: if (last_i) state_nxt = S_DRAIN;
      S_DRAIN:  state_nxt = S_EMIT;
      S_EMIT:   if (hs) state_nxt = last_j ? S_FINISH : S_FETCH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Addresses run one element ahead of the MAC flags to hide read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      mac_start <= 1'b0;
      mac_valid <= 1'b0;
      x_addr    <= '0;
      w_addr    <= '0;
      i         <= '0;
      j         <= '0;
      y.y_valid <= 1'b0;
      y.y_data  <= '0;
      y.y_idx   <= '0;
    end else begin
      done      <= 1'b0;
      mac_start <= 1'b0;
      mac_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_start) begin
            busy   <= 1'b1;
            i      <= '0;
            j      <= '0;
            x_addr <= '0;
            w_addr <= '0;
          end
        end
        S_FETCH: begin
          i         <= '0;
          mac_start <= 1'b1;
          if (N_IN > 1) begin
            x_addr <= x_addr + 1'b1;
            w_addr <= w_addr + 1'b1;
          end
        end
        S_STREAM: begin
          mac_valid <= !last_i;
          if (!last_i) i <= i + 1'b1;
          if (more_addr) begin
            x_addr <= x_addr + 1'b1;
            w_addr <= w_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          y.y_data  <= mac_result;
          y.y_idx   <= j;
          y.y_valid <= 1'b1;
        end
        S_EMIT: begin
          if (hs) begin
            y.y_valid <= 1'b0;
            if (last_j) begin
              done <= 1'b1;
              busy <= 1'b0;
            end else begin
              j      <= j + 1'b1;
              x_addr <= '0;
              w_addr <= w_addr + 1'b1;
            end
          end
        end
        S_FINISH: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_mac_feeder.sv
// Directed bench: feeder + behavioural MAC + two sync ROMs.
// Also a second 1x1 build for the single-input corner.
module tb_mlp_mac_feeder;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cmd_start = 1'b0;
  logic busy, done, mac_start, mac_valid;
  logic [1:0] x_addr;
  logic [3:0] w_addr;
  logic signed [7:0] x_rdata, w_rdata, mac_a, mac_b;
  logic signed [31:0] acc, prod;

  logic cmd2 = 1'b0;
  logic busy2, done2, ms2, mv2;
  logic [0:0] xa2, wa2;
  logic signed [7:0] xr2, wr2, ma2, mb2;
  logic signed [31:0] acc2, prod2;

  logic signed [7:0] xm [4];
  logic signed [7:0] wm [12];

  int tests = 0;
  int fails = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int mcnt = 0;
  logic yv_q = 1'b0;
  int m2s = 0;
  int m2v = 0;
  int lat;

  mlp_mac_feeder_if #(.ACC_WIDTH(32), .YI_W(2)) y();
  mlp_mac_feeder_if #(.ACC_WIDTH(32), .YI_W(1)) y2();

  mlp_mac_feeder dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start),
    .busy(busy), .done(done),
    .x_addr(x_addr), .x_rdata(x_rdata),
    .w_addr(w_addr), .w_rdata(w_rdata),
    .mac_start(mac_start), .mac_valid(mac_valid),
    .mac_a(mac_a), .mac_b(mac_b), .mac_result(acc),
    .y(y.master)
  );

  mlp_mac_feeder #(.N_IN(1), .N_OUT(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd2),
    .busy(busy2), .done(done2),
    .x_addr(xa2), .x_rdata(xr2),
    .w_addr(wa2), .w_rdata(wr2),
    .mac_start(ms2), .mac_valid(mv2),
    .mac_a(ma2), .mac_b(mb2), .mac_result(acc2),
    .y(y2.master)
  );

  always #5 clk = ~clk;

  assign prod  = mac_a * mac_b;
  assign prod2 = ma2 * mb2;

  always @(posedge clk) begin
    x_rdata <= xm[x_addr];
    w_rdata <= wm[w_addr];
    if (mac_start) acc <= prod;
    else if (mac_valid) acc <= acc + prod;
    xr2 <= (xa2 == 1'b0) ? -8'sd7 : 8'sd0;
    wr2 <= (wa2 == 1'b0) ? 8'sd9 : 8'sd0;
    if (ms2) acc2 <= prod2;
    else if (mv2) acc2 <= acc2 + prod2;
    if (y.y_valid && y.y_ready) hs_cnt++;
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag,
             $signed(obs), $signed(exp));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mac_start || mac_valid)
        check("mac_excl", {31'd0, mac_start & mac_valid}, 0);
      if (mac_start) mcnt = 1;
      if (mac_valid) begin
        check("valid_after_start", {31'd0, mcnt != 0}, 1);
        mcnt++;
      end
      if (y.y_valid && !yv_q) begin
        check("mac_cycles", mcnt, 4);
        mcnt = 0;
      end
      yv_q = y.y_valid;
      if (ms2) m2s++;
      if (mv2) m2v++;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_mst"},  {31'd0, mac_start}, 0);
    check({tag, "_mvl"},  {31'd0, mac_valid}, 0);
    check({tag, "_yv"},   {31'd0, y.y_valid}, 0);
    check({tag, "_xa"},   {30'd0, x_addr}, 0);
    check({tag, "_wa"},   {28'd0, w_addr}, 0);
    check({tag, "_yd"},   y.y_data, 0);
    check({tag, "_yi"},   {30'd0, y.y_idx}, 0);
  endtask

  task automatic pulse_and_wait(output int l);
    @(negedge clk);
    cmd_start = 1'b1;
    l = 0;
    do begin
      @(negedge clk);
      cmd_start = 1'b0;
      l++;
    end while (!y.y_valid && l < 60);
  endtask

  task automatic get_y(input string tag, input int idx, input int data);
    int n = 0;
    while (!y.y_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, {31'd0, y.y_valid}, 1);
    check({tag, "_idx"}, {30'd0, y.y_idx}, idx);
    check({tag, "_data"}, y.y_data, data);
    @(negedge clk);
  endtask

  task automatic load(input int xa, input int xb, input int xc,
                      input int xd, input int wv);
    xm[0] = 8'(xa); xm[1] = 8'(xb); xm[2] = 8'(xc); xm[3] = 8'(xd);
    for (int k = 0; k < 12; k++) wm[k] = 8'(wv);
  endtask

  task automatic load_t1();
    load(3, -1, 4, 1, 0);
    wm[0] = 8'sd2; wm[1] = 8'sd5; wm[2] = -8'sd2; wm[3] = 8'sd10;
    for (int k = 4; k < 8; k++) wm[k] = 8'sd1;
  endtask

  initial begin
    y.y_ready  = 1'b1;
    y2.y_ready = 1'b1;
    load_t1();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // basic layer, latency and done
    hs_cnt = 0;
    done_cnt = 0;
    pulse_and_wait(lat);
    check("t1_latency", lat, 7);
    check("t1_busy", {31'd0, busy}, 1);
    get_y("t1_y0", 0, 3);
    get_y("t1_y1", 1, 7);
    get_y("t1_y2", 2, 0);
    check("t1_done", {31'd0, done}, 1);
    check("t1_busy_low", {31'd0, busy}, 0);
    repeat (3) @(negedge clk);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_hs_cnt", hs_cnt, 3);

    // backpressure on neuron 1
    pulse_and_wait(lat);
    get_y("t3_y0", 0, 3);
    y.y_ready = 1'b0;
    lat = 0;
    while (!y.y_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    for (int s = 0; s < 5; s++) begin
      check("t3_hold_v", {31'd0, y.y_valid}, 1);
      check("t3_hold_d", y.y_data, 7);
      check("t3_hold_i", {30'd0, y.y_idx}, 1);
      check("t3_no_mac", {31'd0, mac_start | mac_valid}, 0);
      @(negedge clk);
    end
    y.y_ready = 1'b1;
    @(negedge clk);
    check("t3_released", {31'd0, y.y_valid}, 0);
    get_y("t3_y2", 2, 0);
    repeat (3) @(negedge clk);

    // extremes
    load(-128, -128, -128, -128, -128);
    pulse_and_wait(lat);
    get_y("t4a_y0", 0, 65536);
    get_y("t4a_y1", 1, 65536);
    get_y("t4a_y2", 2, 65536);
    repeat (3) @(negedge clk);
    load(127, 127, 127, 127, -128);
    pulse_and_wait(lat);
    get_y("t4b_y0", 0, -65024);
    get_y("t4b_y1", 1, -65024);
    get_y("t4b_y2", 2, -65024);
    repeat (3) @(negedge clk);

    // abort mid-stream of neuron 1
    load_t1();
    pulse_and_wait(lat);
    get_y("t5_y0", 0, 3);
    @(negedge clk);
    check("t5_xa", {30'd0, x_addr}, 1);
    check("t5_wa", {28'd0, w_addr}, 5);
    check("t5_mst", {31'd0, mac_start}, 1);
    rst_n = 1'b0;
    #1;
    check_zero("t5_abort");
    @(negedge clk);
    rst_n = 1'b1;
    pulse_and_wait(lat);
    check("t5_latency", lat, 7);
    get_y("t5r_y0", 0, 3);
    get_y("t5r_y1", 1, 7);
    get_y("t5r_y2", 2, 0);
    repeat (3) @(negedge clk);

    // cmd_start while busy is ignored
    hs_cnt = 0;
    done_cnt = 0;
    @(negedge clk);
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    repeat (3) @(negedge clk);
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    get_y("t6_y0", 0, 3);
    get_y("t6_y1", 1, 7);
    get_y("t6_y2", 2, 0);
    repeat (12) @(negedge clk);
    check("t6_hs_cnt", hs_cnt, 3);
    check("t6_done_cnt", done_cnt, 1);
    check("t6_busy", {31'd0, busy}, 0);

    // single-input single-neuron build
    m2s = 0;
    m2v = 0;
    @(negedge clk);
    cmd2 = 1'b1;
    @(negedge clk);
    cmd2 = 1'b0;
    lat = 1;
    while (!y2.y_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("t7_latency", lat, 4);
    check("t7_valid", {31'd0, y2.y_valid}, 1);
    check("t7_data", y2.y_data, -63);
    check("t7_idx", {31'd0, y2.y_idx}, 0);
    @(negedge clk);
    check("t7_done", {31'd0, done2}, 1);
    check("t7_starts", m2s, 1);
    check("t7_valids", m2v, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
